// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pipe_hazard_ctrl: stall/bubble control and exception drain/halt FSM for   |
// | the five-stage Y86-64 pipeline. Optional counters under PIPE_PERF_CNT_EN. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module pipe_hazard_ctrl #(
  parameter int         CNT_W    = 32,
  parameter logic [3:0] REG_NONE = 4'hF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       D_icode,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       E_dstM,
  input  logic             e_Cnd,
  input  logic [3:0]       M_icode,
  input  logic [3:0]       m_stat,
  input  logic [3:0]       W_stat,
  output logic             F_stall,
  output logic             D_stall,
  output logic             D_bubble,
  output logic             E_bubble,
  output logic             M_bubble,
  output logic             W_stall,
  output logic             halted,
  output logic [3:0]       halt_stat,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] lu_cnt,
  output logic [CNT_W-1:0] mp_cnt,
  output logic [CNT_W-1:0] ret_cnt
);

  localparam logic [3:0] STAT_AOK = 4'h8;
  localparam logic [3:0] STAT_HLT = 4'h4;
  localparam logic [3:0] STAT_ADR = 4'h2;
  localparam logic [3:0] STAT_INS = 4'h1;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_POPQ   = 4'hB;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic loaduse, mispred, retp, m_exc, w_exc;

  always_comb begin
    loaduse = ((E_icode == I_MRMOVQ) || (E_icode == I_POPQ)) && (E_dstM != REG_NONE) &&
              ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    mispred = (E_icode == I_JXX) && !e_Cnd;
    retp    = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
    m_exc   = (m_stat == STAT_HLT) || (m_stat == STAT_ADR) || (m_stat == STAT_INS);
    w_exc   = (W_stat == STAT_HLT) || (W_stat == STAT_ADR) || (W_stat == STAT_INS);
  end

  // A faulting instruction in W always wins over one still in M.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN: begin
        if (w_exc)      state_nxt = ST_HALT;
        else if (m_exc) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (w_exc)                                         state_nxt = ST_HALT;
        else if ((m_stat == STAT_AOK) && (W_stat == STAT_AOK)) state_nxt = ST_RUN;
      end
      ST_HALT:  state_nxt = ST_HALT;
      default:  state_nxt = ST_RUN;
    endcase
  end

  always_comb begin
    F_stall  = loaduse || retp;
    D_stall  = loaduse;
    D_bubble = !loaduse && (mispred || retp);
    E_bubble = mispred || loaduse;
    M_bubble = m_exc || w_exc || (state == ST_DRAIN);
    W_stall  = w_exc;
    if (state == ST_HALT) begin
      F_stall  = 1'b1;
      D_stall  = 1'b1;
      D_bubble = 1'b0;
      E_bubble = 1'b1;
      M_bubble = 1'b1;
      W_stall  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_RUN;
      halted    <= 1'b0;
      halt_stat <= STAT_AOK;
    end else begin
      state <= state_nxt;
      if ((state != ST_HALT) && (state_nxt == ST_HALT)) begin
        halted    <= 1'b1;
        halt_stat <= W_stat;
      end
    end
  end

`ifdef PIPE_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Saturating counters, frozen while halted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_cnt <= '0;
      lu_cnt  <= '0;
      mp_cnt  <= '0;
      ret_cnt <= '0;
    end else if (state != ST_HALT) begin
      if (cyc_cnt != CNT_MAX)                        cyc_cnt <= cyc_cnt + CNT_ONE;
      if (loaduse && (lu_cnt != CNT_MAX))            lu_cnt  <= lu_cnt + CNT_ONE;
      if (mispred && (mp_cnt != CNT_MAX))            mp_cnt  <= mp_cnt + CNT_ONE;
      if (retp && !loaduse && (ret_cnt != CNT_MAX))  ret_cnt <= ret_cnt + CNT_ONE;
    end
  end
`else
  assign cyc_cnt = '0;
  assign lu_cnt  = '0;
  assign mp_cnt  = '0;
  assign ret_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Pipeline control unit for the five-stage Y86-64 pipeline.
- Generates stall and bubble controls for the F, D, E, M and W pipeline registers from stage icodes, register IDs, branch outcome and stage status.
- Holds an exception/halt state machine that drains the pipe and then freezes it.
- Sits beside the stage modules; its outputs drive their F_stall, D_stall, D_bubble (and equivalent) inputs.

Parameters:
- CNT_W, 32, width of the performance counters (Optional Feature only).
- REG_NONE, 4'hF, register ID meaning "no register".

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- D_icode  input  4  icode in the decode register.
- d_srcA  input  4  decode source A.
- d_srcB  input  4  decode source B.
- E_icode  input  4  icode in the execute register.
- E_dstM  input  4  execute-stage memory destination.
- e_Cnd  input  1  branch condition computed in execute.
- M_icode  input  4  icode in the memory register.
- m_stat  input  4  status out of the memory stage.
- W_stat  input  4  status in the writeback register.
- F_stall  output  1  hold the F register (predPC).
- D_stall  output  1  hold the D register.
- D_bubble  output  1  load nop into D.
- E_bubble  output  1  load nop into E.
- M_bubble  output  1  load nop into M.
- W_stall  output  1  hold the W register.
- halted  output  1  pipeline frozen after an exception.
- halt_stat  output  4  W_stat value that caused the halt.
- cyc_cnt  output  CNT_W  total cycles since reset.
- lu_cnt  output  CNT_W  load/use stall events.
- mp_cnt  output  CNT_W  mispredicted-branch events.
- ret_cnt  output  CNT_W  ret-bubble cycles.

Behaviour:
- Encodings:
  - Stat: AOK=4'h8, HLT=4'h4, ADR=4'h2, INS=4'h1; "exceptional" = HLT, ADR or INS.
  - icode: JXX=7, RET=9, MRMOVQ=5, POPQ=4'hB.
- Combinational terms:
  - loaduse = (E_icode is MRMOVQ or POPQ) && E_dstM != REG_NONE && (E_dstM == d_srcA || E_dstM == d_srcB).
  - mispred = (E_icode == JXX) && !e_Cnd.
  - retp = RET in any of D_icode, E_icode, M_icode.
- State machine: 2-bit state RUN, DRAIN, HALT.
  - RUN -> DRAIN when m_stat is exceptional.
  - RUN or DRAIN -> HALT when W_stat is exceptional (W has priority if both fire in the same cycle).
  - DRAIN -> RUN if m_stat returns to AOK and W_stat is AOK (flushed by mispredict).
  - HALT is exited only by rst.
- Outputs in RUN and DRAIN (combinational, zero-latency):
  - F_stall = loaduse || retp.
  - D_stall = loaduse.
  - D_bubble = mispred || (!loaduse && retp).
  - E_bubble = mispred || loaduse.
  - M_bubble = m_stat exceptional || W_stat exceptional.
  - W_stall = W_stat exceptional.
  - DRAIN additionally forces M_bubble = 1.
- Outputs in HALT: F_stall = D_stall = W_stall = 1, E_bubble = M_bubble = 1, D_bubble = 0. Nothing retires or advances.
- D_stall has priority over D_bubble. D_bubble is never 1 while D_stall is 1.
- halted is registered and goes to 1 on the edge entering HALT. halt_stat captures W_stat on that same edge and holds thereafter.
- Reset (asynchronous, any time, including mid-drain or in HALT) sets:
  - state = RUN, halted = 0, halt_stat = 4'h8, all counters = 0.
  - Control outputs follow the RUN equations while rst is high.
- REG_NONE never matches: E_dstM = 4'hF with d_srcA = 4'hF gives loaduse = 0.

Optional Feature:
- Macro PIPE_PERF_CNT_EN.
- Defined:
  - cyc_cnt increments every cycle not in HALT.
  - lu_cnt increments on cycles with loaduse; mp_cnt on cycles with mispred.
  - ret_cnt increments on cycles with retp && !loaduse.
  - All counters are gated off in HALT, saturate at all-ones (no wrap) and are cleared by rst.
- Undefined: counter ports stay present, are driven constant 0, and no counter flops are built.

Test Plan:
- E_icode=5, E_dstM=3, d_srcA=3, others AOK -> F_stall=1, D_stall=1, E_bubble=1, D_bubble=0, state RUN; with d_srcA=d_srcB=4'hF -> all 0.
- E_icode=7, e_Cnd=0 -> D_bubble=1, E_bubble=1, F_stall=0; with e_Cnd=1 -> all 0.
- D_icode=9 for 3 cycles, then E=9, then M=9 -> F_stall=1 and D_bubble=1 each cycle. Add D/E load-use during ret -> D_stall=1, D_bubble=0.
- m_stat=4'h2 one cycle then W_stat=4'h2 -> M_bubble=1 both cycles, state DRAIN then HALT, halted=1 and halt_stat=2 after the second edge, all freeze outputs held for 10 cycles.
- In HALT assert rst asynchronously mid-cycle -> halted=0 and halt_stat=8 immediately, state RUN, counters 0.
- With PIPE_PERF_CNT_EN: CNT_W=4, run 20 cycles with loaduse every cycle -> cyc_cnt=4'hF and lu_cnt=4'hF (saturated). Without the macro -> all counters read 0.
